// File: rtl/iob_eth_bus_pkg.sv
// Shared encodings for the IOb-native ethoc bus master.
//   - op_e     : command opcodes on cmd_op_i
//   - status_e : response status codes on rsp_status_o
//   - state_e  : bus master FSM states
//   - ethoc register address constants used by the bring-up sequencer
package iob_eth_bus_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_POLL_FAIL = 2'b10,
    ST_BAD_OP    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_e;

  // ethoc register map (word addresses)
  localparam int unsigned INTERRUPT_MASK = 32'h0;
  localparam int unsigned IF_CONTROL     = 32'h1;
  localparam int unsigned READ_FIFO      = 32'h2;
  localparam int unsigned WRITE_FIFO     = 32'h3;
  localparam int unsigned TX_START       = 32'h4;

endpackage

// File: rtl/iob_eth_bus_master.sv
// IOb-native bus master for the ethoc register space.
// Takes write / read / poll-until-match commands on a valid/ready command
// port, performs one IOb access at a time (per-access timeout, bounded poll
// retries) and returns read data, status and read count on a valid/ready
// response port.
//
// Ports:
//   clk_i, arst_i         clock, synchronous active-high reset
//   cmd_*                 command channel (op, addr, wdata/expected, wstrb, poll mask)
//   rsp_*                 response channel (rdata, status, read count)
//   m_*                   IOb-native master interface
module iob_eth_bus_master
  import iob_eth_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int POLL_MAX    = 16,
  parameter int POLL_GAP    = 4,
  parameter int CNT_W       = $clog2(POLL_MAX + 1)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  // command channel
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  input  logic [DATA_W-1:0]   cmd_mask_i,
  // response channel
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_status_o,
  output logic [CNT_W-1:0]    rsp_count_o,
  // IOb master
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_address_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int TMR_MAX = (TIMEOUT_CYC > POLL_GAP) ? TIMEOUT_CYC : POLL_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  status_e             status_q, status_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_inc;
  // Shared down-time counter: cycles waited in WAIT, or cycles spent in GAP.
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                done;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mask_d    = mask_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    count_d   = count_q;
    tmr_d     = tmr_q;
    done      = 1'b0;
    count_inc = (count_q == CNT_W'(POLL_MAX)) ? count_q : count_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = op_e'(cmd_op_i);
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          mask_d  = cmd_mask_i;
          rdata_d = '0;
          count_d = '0;
          tmr_d   = '0;
          // A write with no strobes would look like a read on IOb: reject it.
          if (cmd_op_i == OP_RSV || (cmd_op_i == OP_WR && cmd_wstrb_i == '0)) begin
            status_d = ST_BAD_OP;
            state_d  = S_RESP;
          end else begin
            status_d = ST_OK;
            state_d  = S_REQ;
          end
        end
      end

      S_REQ: begin
        tmr_d = '0;
        if (m_ready_i) begin
          done = 1'b1;
        end else if (TIMEOUT_CYC <= 1) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      // The REQ cycle counts as the first waited cycle, so with tmr_q WAIT
      // cycles already behind us this is cycle tmr_q + 2 of the access; the
      // response therefore lands exactly TIMEOUT_CYC cycles after REQ.
      S_WAIT: begin
        if (m_ready_i) begin
          done = 1'b1;
        end else if (int'(tmr_q) + 2 >= TIMEOUT_CYC) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_GAP: begin
        if (int'(tmr_q) + 1 >= POLL_GAP) begin
          state_d = S_REQ;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Access completion, shared by REQ (zero-wait) and WAIT.
    if (done) begin
      if (op_q == OP_WR) begin
        status_d = ST_OK;
        state_d  = S_RESP;
      end else begin
        rdata_d = m_rdata_i;
        count_d = count_inc;
        if (op_q != OP_POLL || ((m_rdata_i & mask_q) == (wdata_q & mask_q))) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (count_inc == CNT_W'(POLL_MAX)) begin
          status_d = ST_POLL_FAIL;
          state_d  = S_RESP;
        end else begin
          tmr_d   = '0;
          state_d = (POLL_GAP == 0) ? S_REQ : S_GAP;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (arst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      op_q     <= OP_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
      count_q  <= '0;
      tmr_q    <= '0;
    end else begin
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = status_q;
  assign rsp_count_o  = count_q;

  assign m_valid_o    = (state_q == S_REQ);
  assign m_address_o  = addr_q;
  assign m_wdata_o    = wdata_q;
  assign m_wstrb_o    = (state_q == S_REQ && op_q == OP_WR) ? wstrb_q : '0;

endmodule

// File: tb/tb_iob_eth_bus_master.sv
// Directed self-checking bench for iob_eth_bus_master with default
// parameters (TIMEOUT_CYC 256, POLL_MAX 16, POLL_GAP 4). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_iob_eth_bus_master;
  import iob_eth_bus_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  logic                clk_i = 1'b0;
  logic                arst_i;
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_op_i;
  logic [ADDR_W-1:0]   cmd_addr_i;
  logic [DATA_W-1:0]   cmd_wdata_i;
  logic [DATA_W/8-1:0] cmd_wstrb_i;
  logic [DATA_W-1:0]   cmd_mask_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic [1:0]          rsp_status_o;
  logic [CNT_W-1:0]    rsp_count_o;
  logic                m_valid_o;
  logic [ADDR_W-1:0]   m_address_o;
  logic [DATA_W-1:0]   m_wdata_o;
  logic [DATA_W/8-1:0] m_wstrb_o;
  logic [DATA_W-1:0]   m_rdata_i;
  logic                m_ready_i;

  iob_eth_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(256),
    .POLL_MAX(16), .POLL_GAP(4), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .cmd_mask_i(cmd_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_status_o(rsp_status_o), .rsp_count_o(rsp_count_o),
    .m_valid_o(m_valid_o), .m_address_o(m_address_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  int          cyc    = 0;
  int          pulse_cyc[$];
  logic [31:0] rd_q[$];
  int          rsp_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Present one command for a single cycle, then scramble the command inputs
  // so that any use of unregistered fields shows up. Returns in cycle T+1.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] mask);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_wstrb_i = wstrb;
    cmd_mask_i  = mask;
    tick();
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b11;
    cmd_addr_i  = 16'hFFFF;
    cmd_wdata_i = 32'h5A5A_5A5A;
    cmd_wstrb_i = 4'h0;
    cmd_mask_i  = 32'h0;
  endtask

  // Slave model: answers each REQ in the same cycle (if respond) with the
  // next queued word, records REQ cycles, stops when a response appears.
  task automatic run_slave(input string tag, input bit respond, input int budget);
    int n = 0;
    pulse_cyc.delete();
    while (!rsp_valid_o && n < budget) begin
      m_ready_i = 1'b0;
      if (m_valid_o) begin
        pulse_cyc.push_back(cyc);
        if (respond) begin
          m_ready_i = 1'b1;
          m_rdata_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end
      end
      tick();
      n++;
    end
    m_ready_i = 1'b0;
    rsp_cyc   = cyc;
    check({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'd1);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, " idle after ack"}, {62'd0, rsp_valid_o, cmd_ready_o}, 64'b01);
  endtask

  initial begin
    arst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_wstrb_i = '0; cmd_mask_i = '0; rsp_ready_i = 1'b0;
    m_rdata_i = '0; m_ready_i = 1'b0;

    // ---- reset state
    tick(); tick();
    check("reset m_valid", 64'(m_valid_o), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset rsp fields", {rsp_rdata_o, 25'd0, rsp_status_o, rsp_count_o}, 64'd0);
    check("reset m fields", {m_address_o, m_wdata_o, m_wstrb_o}, 64'd0);
    arst_i = 1'b0;
    tick();
    check("reset cmd_ready", 64'(cmd_ready_o), 64'd1);

    // ---- zero-wait write to TX_START
    send_cmd(2'b00, 16'h4, 32'h1, 4'hF, 32'h0);
    check("wr T+1 m_valid", 64'(m_valid_o), 64'd1);
    check("wr T+1 wstrb", 64'(m_wstrb_o), 64'hF);
    check("wr T+1 addr/wdata", {m_address_o, m_wdata_o}, {16'h4, 32'h1});
    check("wr T+1 cmd_ready", 64'(cmd_ready_o), 64'd0);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    check("wr T+2 m_valid", 64'(m_valid_o), 64'd0);
    check("wr T+2 rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("wr rsp", {rsp_rdata_o, 25'd0, rsp_status_o, rsp_count_o}, 64'd0);
    tick();
    check("wr rsp held", {31'd0, rsp_valid_o, 25'd0, rsp_status_o, rsp_count_o}, {31'd0, 1'b1, 32'd0});
    ack_rsp("wr");

    // ---- read IF_CONTROL, ready 3 cycles after valid
    send_cmd(2'b01, 16'h1, 32'h0, 4'hF, 32'h0);
    check("rd REQ valid/strb", {m_valid_o, m_wstrb_o}, {1'b1, 4'h0});
    check("rd REQ addr", 64'(m_address_o), 64'h1);
    tick();
    check("rd WAIT m_valid", 64'(m_valid_o), 64'd0);
    tick(); tick();
    m_ready_i = 1'b1;
    m_rdata_i = 32'hDEAD_BEEF;
    tick();
    m_ready_i = 1'b0;
    m_rdata_i = 32'h0;
    check("rd rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("rd rdata", 64'(rsp_rdata_o), 64'hDEAD_BEEF);
    check("rd status/count", {rsp_status_o, rsp_count_o}, {2'b00, 5'd1});
    ack_rsp("rd");

    // ---- poll READ_FIFO, bit0 set on third read
    rd_q.delete();
    rd_q.push_back(32'hFFFF_FFFE);
    rd_q.push_back(32'h0000_0010);
    rd_q.push_back(32'hABCD_0001);
    send_cmd(2'b10, 16'h2, 32'h1, 4'hF, 32'h1);
    run_slave("poll", 1'b1, 100);
    check("poll pulses", 64'(pulse_cyc.size()), 64'd3);
    if (pulse_cyc.size() == 3) begin
      check("poll gap 1", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd5);
      check("poll gap 2", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd5);
    end
    check("poll status/count", {rsp_status_o, rsp_count_o}, {2'b00, 5'd3});
    check("poll rdata", 64'(rsp_rdata_o), 64'hABCD_0001);
    ack_rsp("poll");

    // ---- poll that never matches
    rd_q.delete();
    send_cmd(2'b10, 16'h2, 32'h1, 4'hF, 32'h1);
    run_slave("pollfail", 1'b1, 200);
    check("pollfail pulses", 64'(pulse_cyc.size()), 64'd16);
    check("pollfail status/count", {rsp_status_o, rsp_count_o}, {2'b10, 5'd16});
    ack_rsp("pollfail");

    // ---- timeout, then a late ready in RESP
    send_cmd(2'b01, 16'h3, 32'h0, 4'h0, 32'h0);
    run_slave("tmo", 1'b0, 400);
    check("tmo pulses", 64'(pulse_cyc.size()), 64'd1);
    if (pulse_cyc.size() == 1)
      check("tmo latency", 64'(rsp_cyc - pulse_cyc[0]), 64'd256);
    check("tmo status/count", {rsp_status_o, rsp_count_o}, {2'b01, 5'd0});
    check("tmo rdata", 64'(rsp_rdata_o), 64'd0);
    m_ready_i = 1'b1;
    m_rdata_i = 32'hCAFE_0000;
    tick(); tick();
    m_ready_i = 1'b0;
    check("late ready ignored", {rsp_rdata_o, 24'd0, rsp_valid_o, m_valid_o, rsp_status_o, rsp_count_o},
          {32'h0, 24'd0, 1'b1, 1'b0, 2'b01, 5'd0});
    ack_rsp("tmo");
    rd_q.delete();
    rd_q.push_back(32'h1234_5678);
    send_cmd(2'b01, 16'h0, 32'h0, 4'h0, 32'h0);
    run_slave("after tmo", 1'b1, 20);
    check("after tmo rsp", {rsp_rdata_o, 25'd0, rsp_status_o, rsp_count_o},
          {32'h1234_5678, 25'd0, 2'b00, 5'd1});
    ack_rsp("after tmo");

    // ---- bad ops: no bus access, immediate BAD_OP response
    send_cmd(2'b11, 16'h1, 32'h0, 4'hF, 32'h0);
    check("op11 rsp", {m_valid_o, rsp_valid_o, rsp_status_o, rsp_count_o}, {1'b0, 1'b1, 2'b11, 5'd0});
    ack_rsp("op11");
    send_cmd(2'b00, 16'h1, 32'h7, 4'h0, 32'h0);
    check("wr strb0 rsp", {m_valid_o, rsp_valid_o, rsp_status_o, rsp_count_o}, {1'b0, 1'b1, 2'b11, 5'd0});
    ack_rsp("wr strb0");

    // ---- reset during WAIT abandons the access
    send_cmd(2'b01, 16'h1, 32'h0, 4'h0, 32'h0);
    tick(); tick();
    check("pre-reset in WAIT", {m_valid_o, rsp_valid_o, cmd_ready_o}, 3'b000);
    arst_i = 1'b1;
    tick();
    check("reset in WAIT outputs", {m_valid_o, rsp_valid_o}, 2'b00);
    arst_i = 1'b0;
    m_ready_i = 1'b1;
    tick(); tick(); tick();
    m_ready_i = 1'b0;
    check("post-reset idle", {m_valid_o, rsp_valid_o, cmd_ready_o}, 3'b001);

    // ---- normal write afterwards
    send_cmd(2'b00, 16'h0, 32'hFF, 4'h1, 32'h0);
    check("post-reset wr strb", {m_valid_o, m_wstrb_o}, {1'b1, 4'h1});
    run_slave("post-reset wr", 1'b1, 20);
    check("post-reset wr rsp", {rsp_status_o, rsp_count_o}, {2'b00, 5'd0});
    ack_rsp("post-reset wr");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
